// File: rtl/seg7_pkg.sv
// Shared types, glyph table and BCD helpers for the
// seven-segment score scanner.
package seg7_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        COMMIT
    } state_t;

    // Active-low cathodes, bit order a..g from bit 6 to bit 0
    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [15:0] MAX_DISPLAY = 16'd9999;
    localparam int          ITER        = 16;

    function automatic logic [15:0] add3(input logic [15:0] b);
        logic [15:0] r;
        r = b;
        for (int i = 0; i < 4; i++) begin
            if (b[i*4 +: 4] >= 4'd5)
                r[i*4 +: 4] = b[i*4 +: 4] + 4'd3;
        end
        return r;
    endfunction

    function automatic logic [6:0] glyph(input logic [3:0] d);
        logic [6:0] g;
        case (d)
            4'd0:    g = SEG_0;
            4'd1:    g = SEG_1;
            4'd2:    g = SEG_2;
            4'd3:    g = SEG_3;
            4'd4:    g = SEG_4;
            4'd5:    g = SEG_5;
            4'd6:    g = SEG_6;
            4'd7:    g = SEG_7;
            4'd8:    g = SEG_8;
            4'd9:    g = SEG_9;
            default: g = SEG_BLANK;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/seg7_if.sv
// Score in, display pins and status out.
// master = score producer, slave = scanner.
interface seg7_if;
    import seg7_pkg::*;

    logic [15:0] score;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        ovf;
    logic        busy;

    modport master (
        output score,
        input  an, seg, dp, ovf, busy
    );

    modport slave (
        input  score,
        output an, seg, dp, ovf, busy
    );

endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one LOAD cycle,
// ITER shift cycles, one COMMIT cycle flagged by done.
module bin2bcd_seq
    import seg7_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] value,
    output logic        load,
    output logic        done,
    output logic        busy,
    output logic [15:0] bcd,
    output logic        ovf
);

    state_t      state;
    state_t      state_nx;
    logic [15:0] bin;
    logic [4:0]  iter;
    logic [31:0] shifted;
    logic        sat;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        load     = 1'b0;
        done     = 1'b0;
        busy     = 1'b1;
        unique case (state)
            IDLE: begin
                busy = 1'b0;
                if (start)
                    state_nx = LOAD;
            end
            LOAD: begin
                load     = 1'b1;
                state_nx = SHIFT;
            end
            SHIFT: begin
                if (iter == 5'(ITER - 1))
                    state_nx = COMMIT;
            end
            COMMIT: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign sat     = value > MAX_DISPLAY;
    // Correct the nibbles before the shift, never after
    assign shifted = {add3(bcd), bin} << 1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bin  <= '0;
            bcd  <= '0;
            iter <= '0;
            ovf  <= 1'b0;
        end else if (load) begin
            bin  <= sat ? MAX_DISPLAY : value;
            bcd  <= '0;
            iter <= '0;
            ovf  <= sat;
        end else if (state == SHIFT) begin
            bcd  <= shifted[31:16];
            bin  <= shifted[15:0];
            iter <= iter + 5'd1;
        end
    end

endmodule

// File: rtl/seg7_score_scanner.sv
// Score change detection, display registers and
// multiplexed common-anode digit scan.
module seg7_score_scanner
    import seg7_pkg::*;
#(
    parameter int REFRESH_BITS  = 18,
    parameter bit BLANK_LEADING = 1'b1
) (
    input logic   clk,
    input logic   reset,
    seg7_if.slave bus
);

    logic [15:0]             last_score;
    logic [15:0]             disp;
    logic                    disp_ovf;
    logic [REFRESH_BITS-1:0] cnt;
    logic [1:0]              sel;
    logic [3:0]              nib;
    logic                    blank;
    logic [3:0]              an_q;
    logic [3:0]              an_nx;
    logic [6:0]              seg_q;
    logic [6:0]              seg_nx;

    logic        start;
    logic        load;
    logic        done;
    logic        busy;
    logic        pend_ovf;
    logic [15:0] bcd;

    assign start = bus.score != last_score;

    bin2bcd_seq u_conv (
        .clk   (clk),
        .rst   (reset),
        .start (start),
        .value (bus.score),
        .load  (load),
        .done  (done),
        .busy  (busy),
        .bcd   (bcd),
        .ovf   (pend_ovf)
    );

    // Digits and overflow flag change together, only on done
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_score <= '0;
            disp       <= '0;
            disp_ovf   <= 1'b0;
        end else begin
            if (load)
                last_score <= bus.score;
            if (done) begin
                disp     <= bcd;
                disp_ovf <= pend_ovf;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt <= '0;
        else
            cnt <= cnt + REFRESH_BITS'(1);
    end

    assign sel = cnt[REFRESH_BITS-1 -: 2];

    always_comb begin
        nib   = disp[{sel, 2'b00} +: 4];
        blank = 1'b0;
        if (BLANK_LEADING) begin
            unique case (sel)
                2'd3:    blank = disp[15:12] == 4'd0;
                2'd2:    blank = disp[15:8] == 8'd0;
                2'd1:    blank = disp[15:4] == 12'd0;
                default: blank = 1'b0;
            endcase
        end
        an_nx  = ~(4'b0001 << sel);
        seg_nx = blank ? SEG_BLANK : glyph(nib);
    end

    // Anode and cathode registered together to avoid ghosting
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            an_q  <= 4'b1110;
            seg_q <= SEG_0;
        end else begin
            an_q  <= an_nx;
            seg_q <= seg_nx;
        end
    end

    assign bus.an   = an_q;
    assign bus.seg  = seg_q;
    assign bus.dp   = 1'b1;
    assign bus.ovf  = disp_ovf;
    assign bus.busy = busy;

endmodule

// File: tb/tb_seg7_score_scanner.sv
// Directed bench for seg7_score_scanner with a 4-bit
// refresh counter, leading-blank and no-blank instances.
module tb_seg7_score_scanner;

    localparam logic [6:0] G0 = 7'b0000001;
    localparam logic [6:0] G1 = 7'b1001111;
    localparam logic [6:0] G2 = 7'b0010010;
    localparam logic [6:0] G3 = 7'b0000110;
    localparam logic [6:0] G4 = 7'b1001100;
    localparam logic [6:0] G5 = 7'b0100100;
    localparam logic [6:0] G7 = 7'b0001111;
    localparam logic [6:0] G9 = 7'b0000100;
    localparam logic [6:0] GB = 7'b1111111;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    seg7_if bus0 ();
    seg7_if bus1 ();

    seg7_score_scanner #(
        .REFRESH_BITS  (4),
        .BLANK_LEADING (1'b1)
    ) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0)
    );

    seg7_score_scanner #(
        .REFRESH_BITS  (4),
        .BLANK_LEADING (1'b0)
    ) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag,
                         input logic [15:0] obs,
                         input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic read_digit(input bit inst, input int d,
                              output logic [6:0] s);
        logic [3:0] want;
        logic [3:0] an_v;
        bit         found;
        want  = ~(4'b0001 << d);
        found = 1'b0;
        s     = 'x;
        for (int i = 0; i < 40; i++) begin
            an_v = inst ? bus1.an : bus0.an;
            if (an_v === want) begin
                found = 1'b1;
                s     = inst ? bus1.seg : bus0.seg;
                break;
            end
            @(negedge clk);
        end
        check("scan_found", {15'd0, found}, 16'd1);
    endtask

    task automatic check_all(input bit inst, input string tag,
                             input logic [6:0] e3, input logic [6:0] e2,
                             input logic [6:0] e1, input logic [6:0] e0);
        logic [6:0] s;
        read_digit(inst, 0, s);
        check({tag, "_d0"}, {9'd0, s}, {9'd0, e0});
        read_digit(inst, 1, s);
        check({tag, "_d1"}, {9'd0, s}, {9'd0, e1});
        read_digit(inst, 2, s);
        check({tag, "_d2"}, {9'd0, s}, {9'd0, e2});
        read_digit(inst, 3, s);
        check({tag, "_d3"}, {9'd0, s}, {9'd0, e3});
    endtask

    // Called on the negedge just after the score changed
    task automatic wait_busy(input string tag);
        int n;
        @(negedge clk);
        check({tag, "_busy_rise"}, {15'd0, bus0.busy}, 16'd1);
        n = 0;
        while (bus0.busy === 1'b1 && n < 60) begin
            n++;
            @(negedge clk);
        end
        check({tag, "_busy_len"}, 16'(n), 16'd18);
        @(negedge clk);
    endtask

    task automatic convert(input logic [15:0] v, input string tag);
        bus0.score = v;
        bus1.score = v;
        wait_busy(tag);
    endtask

    initial begin
        logic [6:0] s;
        bit         seen;
        int         n;
        int         t0;

        reset      = 1'b1;
        bus0.score = 16'd0;
        bus1.score = 16'd0;
        repeat (3) @(negedge clk);
        check("rst_an", {12'd0, bus0.an}, 16'h000e);
        check("rst_seg", {9'd0, bus0.seg}, {9'd0, G0});
        check("rst_dp", {15'd0, bus0.dp}, 16'd1);
        check("rst_ovf", {15'd0, bus0.ovf}, 16'd0);
        check("rst_busy", {15'd0, bus0.busy}, 16'd0);

        reset = 1'b0;
        seen  = 1'b0;
        repeat (100) begin
            @(negedge clk);
            if (bus0.busy !== 1'b0)
                seen = 1'b1;
        end
        check("zero_no_conv", {15'd0, seen}, 16'd0);
        check_all(0, "zero", GB, GB, GB, G0);

        convert(16'd1234, "s1234");
        check_all(0, "s1234", G1, G2, G3, G4);
        read_digit(0, 3, s);
        read_digit(0, 0, s);
        repeat (4) @(negedge clk);
        check("scan_an1", {12'd0, bus0.an}, 16'h000d);
        repeat (4) @(negedge clk);
        check("scan_an2", {12'd0, bus0.an}, 16'h000b);
        repeat (4) @(negedge clk);
        check("scan_an3", {12'd0, bus0.an}, 16'h0007);

        convert(16'd7, "s7");
        check_all(0, "s7", GB, GB, GB, G7);
        check_all(1, "s7_noblank", G0, G0, G0, G7);

        convert(16'd10000, "s10000");
        check("ovf_10000", {15'd0, bus0.ovf}, 16'd1);
        check_all(0, "s10000", G9, G9, G9, G9);
        convert(16'd65535, "s65535");
        check("ovf_65535", {15'd0, bus0.ovf}, 16'd1);
        check_all(0, "s65535", G9, G9, G9, G9);
        convert(16'd42, "s42");
        check("ovf_42", {15'd0, bus0.ovf}, 16'd0);
        check_all(0, "s42", GB, GB, G4, G2);
        convert(16'd9999, "s9999");
        check("ovf_9999", {15'd0, bus0.ovf}, 16'd0);

        bus0.score = 16'd100;
        bus1.score = 16'd100;
        repeat (7) @(negedge clk);
        bus0.score = 16'd200;
        bus1.score = 16'd200;
        n = 0;
        while (bus0.busy === 1'b1 && n < 60) begin
            n++;
            @(negedge clk);
        end
        check("chg_first_done", {15'd0, bus0.busy}, 16'd0);
        t0 = cyc;
        @(negedge clk);
        check("chg_restart", {15'd0, bus0.busy}, 16'd1);
        read_digit(0, 2, s);
        check("chg_first_100", {9'd0, s}, {9'd0, G1});
        n = 0;
        while (bus0.busy === 1'b1 && n < 60) begin
            n++;
            @(negedge clk);
        end
        check("chg_latency", 16'(cyc - t0), 16'd19);
        @(negedge clk);
        check_all(0, "chg200", GB, G2, G0, G0);

        bus0.score = 16'd555;
        bus1.score = 16'd555;
        repeat (6) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("arst_an", {12'd0, bus0.an}, 16'h000e);
        check("arst_seg", {9'd0, bus0.seg}, {9'd0, G0});
        check("arst_busy", {15'd0, bus0.busy}, 16'd0);
        check("arst_ovf", {15'd0, bus0.ovf}, 16'd0);
        @(negedge clk);
        reset = 1'b0;
        wait_busy("s555");
        check_all(0, "s555", GB, G5, G5, G5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
